// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared fetch/decode types and constants
package sys_defs;

   localparam int DEF_NUM_FB    = 8;
   localparam int DEF_NUM_SUPER = 2;

   typedef logic [31:0] INST_t;

   localparam INST_t NOOP_INST = 32'h0000_0013;

   // One fetch slot as presented by the fetch stage
   typedef struct packed {
      logic        valid;
      INST_t       inst;
      logic [63:0] PC;
      logic [63:0] NPC;
      logic [63:0] target;
   } IF_FB_OUT_t;

   // One buffered instruction
   typedef struct packed {
      INST_t       inst;
      logic [63:0] PC;
      logic [63:0] NPC;
      logic [63:0] target;
   } FB_ENTRY_t;

   // Pair presented to the decoder under one shared valid
   typedef struct packed {
      logic             valid;
      INST_t [1:0]      inst;
      logic [1:0][63:0] PC;
      logic [1:0][63:0] NPC;
      logic [1:0][63:0] target;
   } FB_DECODER_OUT_t;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

   function automatic FB_ENTRY_t slot_to_entry(input IF_FB_OUT_t s);
      FB_ENTRY_t e;
      e.inst   = s.inst;
      e.PC     = s.PC;
      e.NPC    = s.NPC;
      e.target = s.target;
      return e;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-wide in-order instruction FIFO between fetch and decode
module fetch_buffer
   import sys_defs::*;
#(
   parameter int NUM_FB    = DEF_NUM_FB,
   parameter int NUM_SUPER = DEF_NUM_SUPER
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_SUPER-1:0]       if_valid,
   input  INST_t [NUM_SUPER-1:0]      if_inst,
   input  logic [NUM_SUPER-1:0][63:0] if_PC,
   input  logic [NUM_SUPER-1:0][63:0] if_NPC,
   input  logic [NUM_SUPER-1:0][63:0] if_target,
   input  logic                       dispatch_en,
   input  logic                       rollback_en,
   output logic                       fb_ready,
   output FB_DECODER_OUT_t            FB_decoder_out,
   output logic [$clog2(NUM_FB):0]    fb_count
);

   localparam int PW = $clog2(NUM_FB);
   localparam int CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   FB_ENTRY_t [NUM_FB-1:0]     entries_q;
   ptr_t                       head_q, head_d, tail_q, tail_d;
   ptr_t                       head_nxt, tail_nxt;
   cnt_t                       count_q, count_d;
   cnt_t                       n_enq;
   logic                       out_valid;
   logic                       enq, deq;
   IF_FB_OUT_t [NUM_SUPER-1:0] if_slot;

   // Bundle each fetch lane into one slot record
   always_comb begin
      if_slot = '0;
      for (int s = 0; s < NUM_SUPER; s++) begin
         if_slot[s].valid  = if_valid[s];
         if_slot[s].inst   = if_inst[s];
         if_slot[s].PC     = if_PC[s];
         if_slot[s].NPC    = if_NPC[s];
         if_slot[s].target = if_target[s];
      end
   end

   // Ready and valid look only at the registered count
   assign fb_ready  = (count_q <= cnt_t'(NUM_FB - 2));
   assign out_valid = (count_q >= cnt_t'(2));
   assign n_enq     = cnt_t'(popcount2({if_slot[1].valid, if_slot[0].valid}));
   assign enq       = fb_ready && (n_enq != '0) && !rollback_en;
   assign deq       = out_valid && dispatch_en && !rollback_en;
   assign head_nxt  = head_q + ptr_t'(1);
   assign tail_nxt  = tail_q + ptr_t'(1);
   assign fb_count  = count_q;

   // Next head/tail/count; rollback overrides any same-cycle traffic
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rollback_en) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + ptr_t'(n_enq);
         if (deq) head_d = head_q + ptr_t'(2);
         count_d = count_q + (enq ? n_enq : cnt_t'(0)) - (deq ? cnt_t'(2) : cnt_t'(0));
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; valid lanes land compacted at tail, slot 0 first
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_FB; i++) begin
            entries_q[i].inst   <= NOOP_INST;
            entries_q[i].PC     <= '0;
            entries_q[i].NPC    <= '0;
            entries_q[i].target <= '0;
         end
      end else if (enq) begin
         if (if_slot[0].valid) entries_q[tail_q] <= slot_to_entry(if_slot[0]);
         if (if_slot[1].valid) entries_q[if_slot[0].valid ? tail_nxt : tail_q] <= slot_to_entry(if_slot[1]);
      end
   end

   // The two oldest entries are always driven, valid or not
   always_comb begin
      FB_decoder_out           = '0;
      FB_decoder_out.valid     = out_valid;
      FB_decoder_out.inst[0]   = entries_q[head_q].inst;
      FB_decoder_out.PC[0]     = entries_q[head_q].PC;
      FB_decoder_out.NPC[0]    = entries_q[head_q].NPC;
      FB_decoder_out.target[0] = entries_q[head_q].target;
      FB_decoder_out.inst[1]   = entries_q[head_nxt].inst;
      FB_decoder_out.PC[1]     = entries_q[head_nxt].PC;
      FB_decoder_out.NPC[1]    = entries_q[head_nxt].NPC;
      FB_decoder_out.target[1] = entries_q[head_nxt].target;
   end

   a_count_bound: assert property (@(posedge clock) disable iff (reset)
      count_q <= cnt_t'(NUM_FB));

   a_deq_pair: assert property (@(posedge clock) disable iff (reset)
      deq |-> (count_q >= cnt_t'(2)));

endmodule
